booth2_seq_mult: RTL

- Sequential radix-4 Booth signed multiplier that sits directly downstream of the Booth partial-product decoders.
- Latches operands A and B and walks the Booth groups of B, one per cycle, starting with group 0 {b1,b0,0}.
- Forms each partial product from the set {0, ±A, ±2A} and accumulates it, shifted by 2i, into a 2*WIDTH-bit product.
- Used as the area-cheap alternative to the Wallace-tree array multiplier, with valid/ready handshakes on both sides.

---
 rtl/booth2_seq_mult_if.sv | 32 +++
 rtl/booth2_seq_mult.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/booth2_seq_mult_if.sv
`default_nettype none
// ============================================================================
//  Module   : booth2_seq_mult_if
//  Purpose  : Operand/result handshake bundle for the radix-4 Booth
//             sequential multiplier. The "slave" modport is the multiplier's
//             view; the "master" modport is the producer/consumer side.
//  Revision : 1.0 - initial release
// ============================================================================
interface booth2_seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic [WIDTH+1:0]     pp_dbg;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy, pp_dbg
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy, pp_dbg
    );
endinterface
`default_nettype wire

// File: rtl/booth2_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module   : booth2_seq_mult
//  Purpose  : Sequential radix-4 Booth signed multiplier. One Booth group of
//             B is decoded and accumulated per cycle; the product is exact
//             for all two's-complement operand pairs.
//  Revision : 1.0 - initial release
// ============================================================================
module booth2_seq_mult #(
    parameter int WIDTH = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    booth2_seq_mult_if.slave       bus
);

    localparam int c_STEPS = WIDTH / 2;
    localparam int c_PPW   = WIDTH + 2;
    localparam int c_PW    = 2 * WIDTH;
    localparam int c_SW    = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;
    localparam logic [c_SW-1:0] c_LAST = c_SW'(c_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic [c_PW-1:0]     r_product;
    logic [c_PPW-1:0]    r_pp_dbg;
    logic [c_SW-1:0]     r_step;
    logic [c_PW-1:0]     r_acc;
    logic [WIDTH:0]      r_pos_a;   // +A, one guard bit
    logic [WIDTH:0]      r_neg_a;   // -A, one guard bit so -(-2^(W-1)) fits
    logic [WIDTH-2:0]    r_bhi;     // not-yet-decoded bits of B, b[2i+1] at LSB
    logic [c_PPW-1:0]    r_pp;      // partial product for the current step

    logic [WIDTH:0]      w_a_ext;
    logic [WIDTH:0]      w_neg_a;
    logic [c_PW-1:0]     w_pp_sext;
    logic [c_PW-1:0]     w_acc_next;
    logic [c_SW:0]       w_shamt;

    // Booth digit select: {0, +-A, +-2A}, sign-extended to WIDTH+2 bits.
    function automatic logic [c_PPW-1:0] booth_pp(
        input logic [2:0]     grp,
        input logic [WIDTH:0] pa,
        input logic [WIDTH:0] na
    );
        logic [c_PPW-1:0] pp;
        case (grp)
            3'b001, 3'b010: pp = {pa[WIDTH], pa};
            3'b011:         pp = {pa, 1'b0};
            3'b100:         pp = {na, 1'b0};
            3'b101, 3'b110: pp = {na[WIDTH], na};
            default:        pp = '0;
        endcase
        return pp;
    endfunction

    // Debug view of a partial product: sign bit inverted, as the decoders emit.
    function automatic logic [c_PPW-1:0] dbg_view(input logic [c_PPW-1:0] pp);
        return {~pp[c_PPW-1], pp[c_PPW-2:0]};
    endfunction

    // Operand extension and the current step's shifted accumulation.
    always_comb begin
        w_a_ext    = {bus.a[WIDTH-1], bus.a};
        w_neg_a    = -w_a_ext;
        w_pp_sext  = {{(c_PW-c_PPW){r_pp[c_PPW-1]}}, r_pp};
        w_shamt    = {r_step, 1'b0};
        w_acc_next = r_acc + (w_pp_sext << w_shamt);
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_product   <= '0;
            r_pp_dbg    <= '0;
            r_step      <= '0;
            r_acc       <= '0;
            r_pos_a     <= '0;
            r_neg_a     <= '0;
            r_bhi       <= '0;
            r_pp        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_state    <= S_CALC;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_pos_a    <= w_a_ext;
                        r_neg_a    <= w_neg_a;
                        r_bhi      <= bus.b[WIDTH-1:1];
                        r_acc      <= '0;
                        r_step     <= '0;
                        // Group 0 is {b1, b0, 0}: decoded straight from the inputs.
                        r_pp       <= booth_pp({bus.b[1:0], 1'b0}, w_a_ext, w_neg_a);
                        r_pp_dbg   <= dbg_view(booth_pp({bus.b[1:0], 1'b0}, w_a_ext, w_neg_a));
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    if (r_step == c_LAST) begin
                        r_state     <= S_DONE;
                        r_product   <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_pp_dbg    <= '0;
                    end else begin
                        // Pre-decode the next group so pp_dbg tracks each CALC cycle.
                        r_step   <= r_step + 1'b1;
                        r_bhi    <= r_bhi >> 2;
                        r_pp     <= booth_pp(r_bhi[2:0], r_pos_a, r_neg_a);
                        r_pp_dbg <= dbg_view(booth_pp(r_bhi[2:0], r_pos_a, r_neg_a));
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_pp_dbg    <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;
    assign bus.busy      = r_busy;
    assign bus.pp_dbg    = r_pp_dbg;

endmodule
`default_nettype wire
